// File: rtl/wb_arbiter.sv
// Writeback arbiter: per-source skid FIFOs feeding up to NUM_WB registered writeback slots, round-robin.
// Optional same-cycle bypass of an empty FIFO is enabled by defining WB_BYPASS_EN.
module wb_arbiter #(
  parameter int unsigned NUM_SRC    = 6,
  parameter int unsigned NUM_WB     = 4,
  parameter int unsigned SKID_DEPTH = 2,
  parameter int unsigned NUM_PR     = 64,
  parameter int unsigned AL_SIZE    = 32,
  parameter int unsigned PR_W       = $clog2(NUM_PR),
  parameter int unsigned AL_W       = $clog2(AL_SIZE)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     ext_stall,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic [NUM_SRC-1:0]       src_ready,
  input  logic [NUM_SRC*PR_W-1:0]  src_rd,
  input  logic [NUM_SRC-1:0]       src_uses_rd,
  input  logic [NUM_SRC*32-1:0]    src_data,
  input  logic [NUM_SRC*AL_W-1:0]  src_al_addr,
  output logic [NUM_WB-1:0]        wb_valid,
  output logic [NUM_WB*PR_W-1:0]   wb_rd,
  output logic [NUM_WB-1:0]        wb_uses_rd,
  output logic [NUM_WB*32-1:0]     wb_data,
  output logic [NUM_WB*AL_W-1:0]   wb_al_addr
);

  localparam int unsigned CNT_W = $clog2(SKID_DEPTH + 1);
  localparam int unsigned RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic [PR_W-1:0] rd;
    logic            uses_rd;
    logic [31:0]     data;
    logic [AL_W-1:0] al_addr;
  } wb_pay_t;

  wb_pay_t          mem_q [NUM_SRC][SKID_DEPTH];
  wb_pay_t          mem_d [NUM_SRC][SKID_DEPTH];
  logic [CNT_W-1:0] cnt_q [NUM_SRC];
  logic [CNT_W-1:0] cnt_d [NUM_SRC];
  logic [RR_W-1:0]  rr_q, rr_d;
  logic [NUM_WB-1:0] wb_valid_q, wb_valid_d;
  wb_pay_t          out_q [NUM_WB];
  wb_pay_t          out_d [NUM_WB];

  wb_pay_t          src_pay [NUM_SRC];
  wb_pay_t          cand_p  [NUM_SRC];
  logic [RR_W-1:0]  ord     [NUM_SRC];
  logic [RR_W-1:0]  rank    [NUM_SRC];
  logic [NUM_SRC-1:0] cand, byp_cand, gnt, push, pop;

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (cnt_q[i] < CNT_W'(SKID_DEPTH));
    end
  end

  // Each source's distance from rr_q in scan order; its rank is the number of
  // candidates that come earlier, which is also its output slot when granted.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      src_pay[i].rd      = src_rd[i*PR_W +: PR_W];
      src_pay[i].uses_rd = src_uses_rd[i];
      src_pay[i].data    = src_data[i*32 +: 32];
      src_pay[i].al_addr = src_al_addr[i*AL_W +: AL_W];
      byp_cand[i] = 1'b0;
`ifdef WB_BYPASS_EN
      byp_cand[i] = (cnt_q[i] == '0) && src_valid[i] && src_ready[i];
`endif
      cand[i]   = (cnt_q[i] != '0) || byp_cand[i];
      cand_p[i] = byp_cand[i] ? src_pay[i] : mem_q[i][0];
      ord[i]    = (RR_W'(i) >= rr_q) ? RR_W'(i) - rr_q
                                     : RR_W'(i) + RR_W'(NUM_SRC) - rr_q;
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      rank[i] = '0;
      for (int unsigned j = 0; j < NUM_SRC; j++) begin
        if (cand[j] && (ord[j] < ord[i])) rank[i] = rank[i] + RR_W'(1);
      end
      gnt[i]  = cand[i] && !ext_stall && !flush && (32'(rank[i]) < NUM_WB);
      pop[i]  = gnt[i] && !byp_cand[i];
      push[i] = src_valid[i] && src_ready[i] && !(gnt[i] && byp_cand[i]);
    end
  end

  always_comb begin : slot_fill
    logic            any;
    logic [RR_W-1:0] last_ord;
    logic [RR_W:0]   nxt;
    any      = 1'b0;
    last_ord = '0;
    for (int unsigned s = 0; s < NUM_WB; s++) begin
      wb_valid_d[s] = 1'b0;
      out_d[s]      = '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        if (gnt[i] && (32'(rank[i]) == s)) begin
          wb_valid_d[s] = 1'b1;
          out_d[s]      = cand_p[i];
        end
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (gnt[i] && (!any || (ord[i] > last_ord))) begin
        any      = 1'b1;
        last_ord = ord[i];
      end
    end
    nxt = {1'b0, rr_q} + {1'b0, last_ord} + (RR_W+1)'(1);
    if (nxt >= (RR_W+1)'(NUM_SRC)) nxt = nxt - (RR_W+1)'(NUM_SRC);
    rr_d = rr_q;
    if (flush)    rr_d = '0;
    else if (any) rr_d = nxt[RR_W-1:0];
  end

  // Shift-down FIFO: slot 0 is the head; a push lands at the post-pop fill level.
  always_comb begin : fifo_next
    logic [CNT_W-1:0] wi;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      mem_d[i] = mem_q[i];
      wi       = cnt_q[i];
      if (pop[i]) begin
        for (int unsigned e = 0; e + 1 < SKID_DEPTH; e++) mem_d[i][e] = mem_q[i][e+1];
        wi = cnt_q[i] - CNT_W'(1);
      end
      if (push[i]) begin
        for (int unsigned e = 0; e < SKID_DEPTH; e++) begin
          if (CNT_W'(e) == wi) mem_d[i][e] = src_pay[i];
        end
      end
      cnt_d[i] = push[i] ? wi + CNT_W'(1) : wi;
      if (flush) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      for (int unsigned j = 0; j < NUM_WB; j++)  out_q[j] <= '0;
      rr_q       <= '0;
      wb_valid_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      rr_q       <= rr_d;
      wb_valid_q <= wb_valid_d;
    end
  end

  always_comb begin
    wb_valid = wb_valid_q;
    for (int unsigned j = 0; j < NUM_WB; j++) begin
      wb_rd[j*PR_W +: PR_W]      = out_q[j].rd;
      wb_uses_rd[j]              = out_q[j].uses_rd;
      wb_data[j*32 +: 32]        = out_q[j].data;
      wb_al_addr[j*AL_W +: AL_W] = out_q[j].al_addr;
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration rules.
module tb_wb_arbiter;

  localparam int NUM_SRC = 6;
  localparam int NUM_WB  = 4;
  localparam int DEPTH   = 2;
  localparam int PR_W    = 6;
  localparam int AL_W    = 5;

  typedef struct packed {
    logic [PR_W-1:0] rd;
    logic            uses_rd;
    logic [31:0]     data;
    logic [AL_W-1:0] al_addr;
  } pay_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0, ext_stall = 1'b0;
  logic [NUM_SRC-1:0]      src_valid = '0;
  logic [NUM_SRC-1:0]      src_ready;
  logic [NUM_SRC*PR_W-1:0] src_rd = '0;
  logic [NUM_SRC-1:0]      src_uses_rd = '0;
  logic [NUM_SRC*32-1:0]   src_data = '0;
  logic [NUM_SRC*AL_W-1:0] src_al_addr = '0;
  logic [NUM_WB-1:0]       wb_valid;
  logic [NUM_WB*PR_W-1:0]  wb_rd;
  logic [NUM_WB-1:0]       wb_uses_rd;
  logic [NUM_WB*32-1:0]    wb_data;
  logic [NUM_WB*AL_W-1:0]  wb_al_addr;

  wb_arbiter #(.NUM_SRC(NUM_SRC), .NUM_WB(NUM_WB), .SKID_DEPTH(DEPTH),
               .NUM_PR(64), .AL_SIZE(32)) dut (
    .clk(clk), .reset(reset), .flush(flush), .ext_stall(ext_stall),
    .src_valid(src_valid), .src_ready(src_ready), .src_rd(src_rd),
    .src_uses_rd(src_uses_rd), .src_data(src_data), .src_al_addr(src_al_addr),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_uses_rd(wb_uses_rd),
    .wb_data(wb_data), .wb_al_addr(wb_al_addr));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  pay_t              mq [NUM_SRC][$];
  int                m_rr;
  logic [NUM_WB-1:0] exp_v;
  pay_t              exp_p [NUM_WB];

  task automatic model_reset();
    for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
    m_rr  = 0;
    exp_v = '0;
  endtask

  function automatic logic [NUM_SRC-1:0] model_ready();
    logic [NUM_SRC-1:0] r;
    for (int i = 0; i < NUM_SRC; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  task automatic model_step();
    pay_t inp [NUM_SRC];
    logic [NUM_SRC-1:0] rdy;
    bit byp [NUM_SRC];
    bit popq [NUM_SRC];
    int n, last, s;
    rdy = model_ready();
    for (int i = 0; i < NUM_SRC; i++) begin
      inp[i].rd      = src_rd[i*PR_W +: PR_W];
      inp[i].uses_rd = src_uses_rd[i];
      inp[i].data    = src_data[i*32 +: 32];
      inp[i].al_addr = src_al_addr[i*AL_W +: AL_W];
      byp[i] = 0;
      popq[i] = 0;
    end
    exp_v = '0;
    if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
      m_rr = 0;
      return;
    end
    n = 0;
    last = -1;
    if (!ext_stall) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        s = (m_rr + k) % NUM_SRC;
        if (n < NUM_WB && mq[s].size() > 0) begin
          exp_p[n] = mq[s][0];
          exp_v[n] = 1'b1;
          popq[s] = 1;
          n++;
          last = s;
        end
`ifdef WB_BYPASS_EN
        else if (n < NUM_WB && mq[s].size() == 0 && src_valid[s] && rdy[s]) begin
          exp_p[n] = inp[s];
          exp_v[n] = 1'b1;
          byp[s] = 1;
          n++;
          last = s;
        end
`endif
      end
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      if (popq[i]) void'(mq[i].pop_front());
      if (src_valid[i] && rdy[i] && !byp[i]) mq[i].push_back(inp[i]);
    end
    if (last >= 0) m_rr = (last + 1) % NUM_SRC;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(int i, logic [PR_W-1:0] rd, logic u, logic [31:0] d, logic [AL_W-1:0] a);
    src_valid[i]                = 1'b1;
    src_rd[i*PR_W +: PR_W]      = rd;
    src_uses_rd[i]              = u;
    src_data[i*32 +: 32]        = d;
    src_al_addr[i*AL_W +: AL_W] = a;
  endtask

  function automatic pay_t got_slot(int j);
    pay_t p;
    p.rd      = wb_rd[j*PR_W +: PR_W];
    p.uses_rd = wb_uses_rd[j];
    p.data    = wb_data[j*32 +: 32];
    p.al_addr = wb_al_addr[j*AL_W +: AL_W];
    return p;
  endfunction

  task automatic test_reset();
    @(posedge clk);
    #1;
    n_tests++;
    if (wb_valid !== '0 || wb_rd !== '0 || wb_data !== '0 || wb_al_addr !== '0 || wb_uses_rd !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b rd=%h data=%h al=%h uses=%b, required all zero",
               wb_valid, wb_rd, wb_data, wb_al_addr, wb_uses_rd);
    end
    reset = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (src_ready !== 6'b111111) begin
      n_fail++;
      $display("FAIL reset_ready: got %b required 111111", src_ready);
    end
  endtask

  task automatic test_reset_release();
    pay_t g;
    set_src(0, 6'd5, 1'b1, 32'hDEADBEEF, 5'd3);
    tick();
    src_valid = '0;
`ifndef WB_BYPASS_EN
    n_tests++;
    if (wb_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL release_early: wb_valid got %b required 0000", wb_valid);
    end
    tick();
`endif
    g = got_slot(0);
    n_tests++;
    if (wb_valid !== 4'b0001 || g.rd !== 6'd5 || g.data !== 32'hDEADBEEF || g.al_addr !== 5'd3) begin
      n_fail++;
      $display("FAIL release_first: valid=%b rd=%0d data=%h al=%0d required 0001/5/deadbeef/3",
               wb_valid, g.rd, g.data, g.al_addr);
    end
    tick();
    n_tests++;
    if (wb_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL release_drain: wb_valid got %b required 0000", wb_valid);
    end
  endtask

  task automatic test_all_six();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 6'(i + 1), 1'b1, 32'hA000_0000 + 32'(i), 5'(i));
    tick();
    src_valid = '0;
    tick();
    n_tests++;
    if (wb_valid !== 4'b1111) begin
      n_fail++;
      $display("FAIL six_first_valid: got %b required 1111", wb_valid);
    end
    for (int j = 0; j < NUM_WB; j++) begin
      n_tests++;
      if (got_slot(j).data !== 32'hA000_0000 + 32'(j)) begin
        n_fail++;
        $display("FAIL six_first_slot%0d: data %h required %h", j, got_slot(j).data, 32'hA000_0000 + 32'(j));
      end
    end
    tick();
    n_tests++;
    if (wb_valid !== 4'b0011 || got_slot(0).data !== 32'hA000_0004 || got_slot(1).data !== 32'hA000_0005) begin
      n_fail++;
      $display("FAIL six_second: valid=%b s0=%h s1=%h required 0011/a0000004/a0000005",
               wb_valid, got_slot(0).data, got_slot(1).data);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] want [4];
    set_src(4, 6'd40, 1'b1, 32'hB000_0004, 5'd4);
    tick();
    src_valid = '0;
    tick();
    n_tests++;
    if (wb_valid !== 4'b0001 || got_slot(0).data !== 32'hB000_0004) begin
      n_fail++;
      $display("FAIL wrap_setup: valid=%b data=%h required 0001/b0000004", wb_valid, got_slot(0).data);
    end
    for (int i = 0; i < NUM_SRC; i++)
      if (i != 4) set_src(i, 6'(20 + i), 1'b0, 32'hC000_0000 + 32'(i), 5'(i));
    tick();
    src_valid = '0;
    tick();
    want = '{32'hC000_0005, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002};
    n_tests++;
    if (wb_valid !== 4'b1111) begin
      n_fail++;
      $display("FAIL wrap_valid: got %b required 1111", wb_valid);
    end
    for (int j = 0; j < NUM_WB; j++) begin
      n_tests++;
      if (got_slot(j).data !== want[j] || got_slot(j).uses_rd !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_slot%0d: data %h uses %b required %h/0", j, got_slot(j).data, got_slot(j).uses_rd, want[j]);
      end
    end
    tick();
    n_tests++;
    if (wb_valid !== 4'b0001 || got_slot(0).data !== 32'hC000_0003) begin
      n_fail++;
      $display("FAIL wrap_tail: valid=%b data=%h required 0001/c0000003", wb_valid, got_slot(0).data);
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] want [3];
    want = '{32'hD000_000A, 32'hD000_000B, 32'hD000_000C};
    ext_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_src(2, 6'(10 + k), 1'b1, want[k], 5'(k));
      tick();
      n_tests++;
      if (wb_valid !== 4'b0000 || src_ready[2] !== (k == 0)) begin
        n_fail++;
        $display("FAIL bp_stall%0d: valid=%b ready2=%b required 0000/%0d", k, wb_valid, src_ready[2], k == 0);
      end
    end
    ext_stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 1) src_valid = '0;
      n_tests++;
      if (wb_valid !== 4'b0001 || got_slot(0).data !== want[k]) begin
        n_fail++;
        $display("FAIL bp_drain%0d: valid=%b data=%h required 0001/%h", k, wb_valid, got_slot(0).data, want[k]);
      end
    end
    tick();
    n_tests++;
    if (wb_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_empty: valid=%b required 0000", wb_valid);
    end
  endtask

  task automatic test_flush();
    ext_stall = 1'b1;
    for (int i = 0; i < 4; i++) set_src(i, 6'(30 + i), 1'b1, 32'hE000_0000 + 32'(i), 5'(i));
    tick();
    src_valid = '0;
    ext_stall = 1'b0;
    flush = 1'b1;
    set_src(4, 6'd44, 1'b1, 32'hF1A5_F1A5, 5'd9);
    tick();
    flush = 1'b0;
    src_valid = '0;
    n_tests++;
    if (wb_valid !== 4'b0000 || src_ready !== 6'b111111) begin
      n_fail++;
      $display("FAIL flush_now: valid=%b ready=%b required 0000/111111", wb_valid, src_ready);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (wb_valid !== 4'b0000) begin
        n_fail++;
        $display("FAIL flush_after%0d: valid=%b required 0000", k, wb_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 6'(50 + i), 1'b1, 32'h5000_0000 + 32'(i), 5'(i));
    tick();
    src_valid = '0;
    tick();
    n_tests++;
    if (wb_valid !== 4'b1111) begin
      n_fail++;
      $display("FAIL areset_pre: valid=%b required 1111", wb_valid);
    end
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (wb_valid !== 4'b0000 || wb_data !== '0) begin
      n_fail++;
      $display("FAIL areset_immediate: valid=%b data=%h required 0000/0", wb_valid, wb_data);
    end
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (wb_valid !== 4'b0000 || src_ready !== 6'b111111) begin
        n_fail++;
        $display("FAIL areset_after%0d: valid=%b ready=%b required 0000/111111", k, wb_valid, src_ready);
      end
    end
  endtask

  task automatic test_random();
    pay_t g;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        src_valid[i] = ($urandom_range(0, 9) < 6);
        src_rd[i*PR_W +: PR_W]      = 6'($urandom);
        src_uses_rd[i]              = 1'($urandom);
        src_data[i*32 +: 32]        = $urandom;
        src_al_addr[i*AL_W +: AL_W] = 5'($urandom);
      end
      ext_stall = ($urandom_range(0, 99) < 15);
      flush     = ($urandom_range(0, 99) < 3);
      tick();
      n_tests++;
      if (wb_valid !== exp_v) begin
        n_fail++;
        $display("FAIL rand_valid c=%0d: got %b required %b", c, wb_valid, exp_v);
      end
      for (int j = 0; j < NUM_WB; j++) begin
        if (exp_v[j]) begin
          g = got_slot(j);
          n_tests++;
          if (g !== exp_p[j]) begin
            n_fail++;
            $display("FAIL rand_slot%0d c=%0d: got %h required %h", j, c, g, exp_p[j]);
          end
        end
      end
      n_tests++;
      if (src_ready !== model_ready()) begin
        n_fail++;
        $display("FAIL rand_ready c=%0d: got %b required %b", c, src_ready, model_ready());
      end
    end
    src_valid = '0;
    ext_stall = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_release();
    test_all_six();
    test_wrap();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
